// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: load-use bubbles,
// branch/jump flushes and a data-memory freeze with timeout and stall counting.
module pipeline_hazard_ctrl #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [4:0]       i_id_rs,
   input  logic [4:0]       i_id_rt,
   input  logic             i_id_useRs,
   input  logic             i_id_useRt,
   input  logic             i_id_jump,
   input  logic             i_ex_memRead,
   input  logic [4:0]       i_ex_rt,
   input  logic             i_mem_pcSrc,
   input  logic             i_mem_access,
   input  logic             i_dmem_ready,
   output logic             o_pcWrite,
   output logic             o_ifidWrite,
   output logic             o_ifidFlush,
   output logic             o_idexFlush,
   output logic             o_exmemFlush,
   output logic             o_freeze,
   output logic             o_memError,
   output logic [CNT_W-1:0] o_stallCnt,
   output logic [1:0]       o_state
);

   localparam int unsigned WC_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WC_W-1:0] WC_LIMIT = WC_W'(MEM_TIMEOUT);

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_MEMWAIT = 2'd1,
      S_ERROR   = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [WC_W-1:0]   waitCnt_q, waitCnt_d;
   logic              memError_q, memError_d;
   logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;

   logic mem_wait;
   logic rs_hit;
   logic rt_hit;
   logic load_use;

   assign mem_wait = i_mem_access & ~i_dmem_ready;
   assign rs_hit   = i_id_useRs & (i_id_rs == i_ex_rt);
   assign rt_hit   = i_id_useRt & (i_id_rt == i_ex_rt);
   // $0 is hardwired zero, so a load targeting it can never feed a consumer
   assign load_use = i_ex_memRead & (i_ex_rt != 5'd0) & (rs_hit | rt_hit);

   always_comb begin
      o_pcWrite    = 1'b0;
      o_ifidWrite  = 1'b0;
      o_ifidFlush  = 1'b0;
      o_idexFlush  = 1'b0;
      o_exmemFlush = 1'b0;
      o_freeze     = 1'b0;
      if (i_rst) begin
         o_ifidFlush  = 1'b1;
         o_idexFlush  = 1'b1;
         o_exmemFlush = 1'b1;
      end else if ((state_q == S_ERROR) || mem_wait) begin
         o_freeze = 1'b1;
      end else if (i_mem_pcSrc) begin
         o_pcWrite    = 1'b1;
         o_ifidWrite  = 1'b1;
         o_ifidFlush  = 1'b1;
         o_idexFlush  = 1'b1;
         o_exmemFlush = 1'b1;
      end else if (i_id_jump) begin
         o_pcWrite   = 1'b1;
         o_ifidWrite = 1'b1;
         o_ifidFlush = 1'b1;
      end else if (load_use) begin
         o_idexFlush = 1'b1;
      end else begin
         o_pcWrite   = 1'b1;
         o_ifidWrite = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      waitCnt_d  = waitCnt_q;
      memError_d = memError_q;
      case (state_q)
         S_RUN: begin
            if (mem_wait) begin
               state_d   = S_MEMWAIT;
               waitCnt_d = WC_W'(1);
            end
         end
         S_MEMWAIT: begin
            // waitCnt holds the number of wait cycles already seen before this one
            if (!mem_wait) begin
               state_d   = S_RUN;
               waitCnt_d = '0;
            end else if (waitCnt_q == WC_LIMIT) begin
               state_d    = S_ERROR;
               memError_d = 1'b1;
            end else begin
               waitCnt_d = waitCnt_q + WC_W'(1);
            end
         end
         S_ERROR: begin
            state_d = S_ERROR;
         end
         default: begin
            state_d   = S_RUN;
            waitCnt_d = '0;
         end
      endcase
   end

   always_comb begin
      stallCnt_d = stallCnt_q;
      if (!o_pcWrite && (stallCnt_q != '1)) begin
         stallCnt_d = stallCnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_RUN;
         waitCnt_q  <= '0;
         memError_q <= 1'b0;
         stallCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         waitCnt_q  <= waitCnt_d;
         memError_q <= memError_d;
         stallCnt_q <= stallCnt_d;
      end
   end

   assign o_memError = memError_q;
   assign o_stallCnt = stallCnt_q;
   assign o_state    = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: one instance with default parameters,
// one with CNT_W=4 / MEM_TIMEOUT=3 for timeout and saturation boundaries.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       useRs, useRt, id_jump, ex_memRead, mem_pcSrc, mem_access, dmem_ready;

   logic        pcW_a, ifW_a, ifF_a, idF_a, exF_a, frz_a, err_a;
   logic [15:0] cnt_a;
   logic [1:0]  st_a;
   logic        pcW_b, ifW_b, ifF_b, idF_b, exF_b, frz_b, err_b;
   logic [3:0]  cnt_b;
   logic [1:0]  st_b;

   logic [5:0] ctl_a, ctl_b;
   assign ctl_a = {pcW_a, ifW_a, ifF_a, idF_a, exF_a, frz_a};
   assign ctl_b = {pcW_b, ifW_b, ifF_b, idF_b, exF_b, frz_b};

   // ctl = {pcWrite, ifidWrite, ifidFlush, idexFlush, exmemFlush, freeze}
   localparam logic [5:0] C_RESET  = 6'b001110;
   localparam logic [5:0] C_NORMAL = 6'b110000;
   localparam logic [5:0] C_LOADU  = 6'b000100;
   localparam logic [5:0] C_BRANCH = 6'b111110;
   localparam logic [5:0] C_JUMP   = 6'b111000;
   localparam logic [5:0] C_FREEZE = 6'b000001;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(15)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_id_rs(id_rs), .i_id_rt(id_rt),
      .i_id_useRs(useRs), .i_id_useRt(useRt), .i_id_jump(id_jump),
      .i_ex_memRead(ex_memRead), .i_ex_rt(ex_rt), .i_mem_pcSrc(mem_pcSrc),
      .i_mem_access(mem_access), .i_dmem_ready(dmem_ready),
      .o_pcWrite(pcW_a), .o_ifidWrite(ifW_a), .o_ifidFlush(ifF_a),
      .o_idexFlush(idF_a), .o_exmemFlush(exF_a), .o_freeze(frz_a),
      .o_memError(err_a), .o_stallCnt(cnt_a), .o_state(st_a)
   );

   pipeline_hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(3)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_id_rs(id_rs), .i_id_rt(id_rt),
      .i_id_useRs(useRs), .i_id_useRt(useRt), .i_id_jump(id_jump),
      .i_ex_memRead(ex_memRead), .i_ex_rt(ex_rt), .i_mem_pcSrc(mem_pcSrc),
      .i_mem_access(mem_access), .i_dmem_ready(dmem_ready),
      .o_pcWrite(pcW_b), .o_ifidWrite(ifW_b), .o_ifidFlush(ifF_b),
      .o_idexFlush(idF_b), .o_exmemFlush(exF_b), .o_freeze(frz_b),
      .o_memError(err_b), .o_stallCnt(cnt_b), .o_state(st_b)
   );

   task automatic clear_inputs();
      rst = 1'b0; id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
      useRs = 1'b0; useRt = 1'b0; id_jump = 1'b0; ex_memRead = 1'b0;
      mem_pcSrc = 1'b0; mem_access = 1'b0; dmem_ready = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      #2;
      vectors++;
      if (ctl_a !== C_RESET) begin
         miscompares++;
         $display("FAIL reset_ctl: got %b expected %b", ctl_a, C_RESET);
      end
      tick();
      rst = 1'b0;
      #1;
      vectors++;
      if ({st_a, err_a, cnt_a} !== {2'd0, 1'b0, 16'd0} || {st_b, err_b, cnt_b} !== {2'd0, 1'b0, 4'd0}) begin
         miscompares++;
         $display("FAIL reset_state: got a=%0d/%b/%0d b=%0d/%b/%0d expected 0/0/0",
                  st_a, err_a, cnt_a, st_b, err_b, cnt_b);
      end
      vectors++;
      if (ctl_a !== C_NORMAL) begin
         miscompares++;
         $display("FAIL idle_ctl: got %b expected %b", ctl_a, C_NORMAL);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      ex_memRead = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; useRs = 1'b1;
      #2;
      vectors++;
      if (ctl_a !== C_LOADU) begin
         miscompares++;
         $display("FAIL loaduse_rs_ctl: got %b expected %b", ctl_a, C_LOADU);
      end
      tick();
      vectors++;
      if (cnt_a !== 16'd1) begin
         miscompares++;
         $display("FAIL loaduse_cnt: got %0d expected 1", cnt_a);
      end
      // load has moved to MEM: no further bubble
      ex_memRead = 1'b0;
      #2;
      vectors++;
      if (ctl_a !== C_NORMAL) begin
         miscompares++;
         $display("FAIL loaduse_release: got %b expected %b", ctl_a, C_NORMAL);
      end
      tick();
      ex_memRead = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
      #2;
      vectors++;
      if (ctl_a !== C_NORMAL) begin
         miscompares++;
         $display("FAIL loaduse_r0: got %b expected %b", ctl_a, C_NORMAL);
      end
      tick();
      ex_rt = 5'd9; id_rt = 5'd9; useRs = 1'b0; useRt = 1'b1; id_rs = 5'd3;
      #2;
      vectors++;
      if (ctl_a !== C_LOADU) begin
         miscompares++;
         $display("FAIL loaduse_rt_ctl: got %b expected %b", ctl_a, C_LOADU);
      end
      tick();
      useRt = 1'b0;
      #2;
      vectors++;
      if (ctl_a !== C_NORMAL) begin
         miscompares++;
         $display("FAIL loaduse_unused_rt: got %b expected %b", ctl_a, C_NORMAL);
      end
      tick();
      vectors++;
      if (cnt_a !== 16'd2) begin
         miscompares++;
         $display("FAIL loaduse_cnt2: got %0d expected 2", cnt_a);
      end
   endtask

   task automatic test_branch();
      do_reset();
      ex_memRead = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; useRs = 1'b1;
      id_jump = 1'b1; mem_pcSrc = 1'b1;
      #2;
      vectors++;
      if (ctl_a !== C_BRANCH) begin
         miscompares++;
         $display("FAIL branch_ctl: got %b expected %b", ctl_a, C_BRANCH);
      end
      tick();
      vectors++;
      if (cnt_a !== 16'd0) begin
         miscompares++;
         $display("FAIL branch_cnt: got %0d expected 0", cnt_a);
      end
      mem_pcSrc = 1'b0;
      #2;
      vectors++;
      if (ctl_a !== C_JUMP) begin
         miscompares++;
         $display("FAIL jump_over_loaduse: got %b expected %b", ctl_a, C_JUMP);
      end
      tick();
   endtask

   task automatic test_mem_wait();
      do_reset();
      mem_access = 1'b1; dmem_ready = 1'b0; mem_pcSrc = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #2;
         vectors++;
         if (ctl_a !== C_FREEZE) begin
            miscompares++;
            $display("FAIL wait_ctl[%0d]: got %b expected %b", i, ctl_a, C_FREEZE);
         end
         tick();
         vectors++;
         if (st_a !== 2'd1) begin
            miscompares++;
            $display("FAIL wait_state[%0d]: got %0d expected 1", i, st_a);
         end
      end
      dmem_ready = 1'b1;
      #2;
      vectors++;
      if (ctl_a !== C_BRANCH) begin
         miscompares++;
         $display("FAIL wait_release_branch: got %b expected %b", ctl_a, C_BRANCH);
      end
      tick();
      vectors++;
      if ({st_a, err_a, cnt_a} !== {2'd0, 1'b0, 16'd4}) begin
         miscompares++;
         $display("FAIL wait_done: got st=%0d err=%b cnt=%0d expected st=0 err=0 cnt=4",
                  st_a, err_a, cnt_a);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      mem_access = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      vectors++;
      if ({st_b, err_b} !== {2'd1, 1'b0}) begin
         miscompares++;
         $display("FAIL timeout_pre: got st=%0d err=%b expected st=1 err=0", st_b, err_b);
      end
      tick();
      vectors++;
      if ({st_b, err_b} !== {2'd2, 1'b1}) begin
         miscompares++;
         $display("FAIL timeout_err: got st=%0d err=%b expected st=2 err=1", st_b, err_b);
      end
      dmem_ready = 1'b1;
      #2;
      vectors++;
      if (ctl_b !== C_FREEZE || ctl_a !== C_NORMAL) begin
         miscompares++;
         $display("FAIL timeout_hold: got b=%b a=%b expected b=%b a=%b", ctl_b, ctl_a, C_FREEZE, C_NORMAL);
      end
      tick();
      vectors++;
      if ({st_b, err_b} !== {2'd2, 1'b1}) begin
         miscompares++;
         $display("FAIL timeout_sticky: got st=%0d err=%b expected st=2 err=1", st_b, err_b);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if ({st_b, err_b, cnt_b} !== {2'd0, 1'b0, 4'd0}) begin
         miscompares++;
         $display("FAIL timeout_reset: got st=%0d err=%b cnt=%0d expected 0/0/0", st_b, err_b, cnt_b);
      end
   endtask

   task automatic test_ready_at_limit();
      do_reset();
      mem_access = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      dmem_ready = 1'b1;
      tick();
      vectors++;
      if ({st_b, err_b, cnt_b} !== {2'd0, 1'b0, 4'd3}) begin
         miscompares++;
         $display("FAIL ready_at_limit: got st=%0d err=%b cnt=%0d expected st=0 err=0 cnt=3",
                  st_b, err_b, cnt_b);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      ex_memRead = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; useRs = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      vectors++;
      if (cnt_b !== 4'd15 || cnt_a !== 16'd20) begin
         miscompares++;
         $display("FAIL saturation: got b=%0d a=%0d expected b=15 a=20", cnt_b, cnt_a);
      end
   endtask

   initial begin
      clear_inputs();
      #1;
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_ready_at_limit();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
